// File: rtl/spi_byte_sequencer.sv
// Command sequencer in front of a byte-level SPI master: issues tx bytes one at a time and
// collects rx bytes into a first-word-fall-through FIFO. Optional watchdog: SPI_SEQ_TIMEOUT_EN.
module spi_byte_sequencer #(
  parameter int SLAVE_COUNT    = 1,
  parameter int SEL_W          = 1,
  parameter int LEN_W          = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SEL_W-1:0]       cmd_slave,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   m_spi_ready,
  output logic [7:0]             m_tx_byte,
  output logic                   m_tx_byte_valid,
  output logic [SLAVE_COUNT-1:0] m_ss_in,
  input  logic [7:0]             m_rx_byte,
  input  logic                   m_rx_byte_valid,
  output logic [1:0]             dbg_state
);

  // Handshakes (cmd, tx, rx): a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready may depend only on local state.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ISSUE = 2'd2, WAIT_RX = 2'd3} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [SEL_W:0] SLAVE_LIMIT = (SEL_W+1)'(SLAVE_COUNT);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [7:0]       byte_q;
  logic [SEL_W-1:0] slave_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             done_q, err_q;
  logic             load_cmd, load_byte, push, pop, done_d, err_d;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout;

  // Counter is zero on the first WAIT_RX cycle because it clears in every other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  to_cnt_q <= '0;
    else if (state_q != WAIT_RX) to_cnt_q <= '0;
    else                         to_cnt_q <= to_cnt_q + TO_W'(1);
  end
  assign timeout = (to_cnt_q == TO_LAST);
`endif

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign tx_ready        = (state_q == FETCH) && (count_q < FIFO_FULL);
  assign m_tx_byte_valid = (state_q == ISSUE) && m_spi_ready;
  assign m_tx_byte       = byte_q;
  assign rx_valid        = (count_q != '0);
  assign rx_data         = rx_valid ? mem[rd_ptr_q] : 8'h00;
  assign pop             = rx_valid && rx_ready;
  assign done            = done_q;
  assign err             = err_q;
  assign dbg_state       = state_q;

  always_comb begin
    m_ss_in = '1;
    if (state_q != IDLE) begin
      for (int i = 0; i < SLAVE_COUNT; i++) begin
        if (slave_q == SEL_W'(i)) m_ss_in[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load_cmd  = 1'b0;
    load_byte = 1'b0;
    push      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if ({1'b0, cmd_slave} >= SLAVE_LIMIT) err_d = 1'b1;
          else if (cmd_len == '0)              done_d = 1'b1;
          else begin
            load_cmd = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (tx_valid && tx_ready) begin
          load_byte = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_spi_ready) state_d = WAIT_RX;
      end
      WAIT_RX: begin
        if (m_rx_byte_valid) begin
          push = 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      byte_q      <= 8'h00;
      slave_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (load_cmd) begin
        slave_q     <= cmd_slave;
        remaining_q <= cmd_len;
      end else if (push) begin
        remaining_q <= remaining_q - LEN_W'(1);
      end
      if (load_byte) byte_q <= tx_data;
    end
  end

  // FIFO cannot overflow: a slot is reserved by tx_ready before the byte goes out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= m_rx_byte;
  end

endmodule
